// File: rtl/frame_serializer_if.sv
// Frame-in / word-out handshake bundle for frame_serializer.
// master drives frames and consumes words; slave is the serializer.
interface frame_serializer_if #(
   parameter int count = 4,
   parameter int width = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [count*width-1:0]   in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [width-1:0]         out_data;
   logic                     out_last;
   logic                     busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, busy
   );
endinterface

// File: rtl/frame_serializer.sv
// Splits a count-word frame into width-bit words, lowest first; first word 1 cycle after load.
// Stalls hold the word stable; next frame loads on the last-word transfer cycle (no bubble).
module frame_serializer #(
   parameter int count = 4,
   parameter int width = 8
) (
   input logic               clock,
   input logic               reset,
   frame_serializer_if.slave bus
);
   localparam int rw = (count > 1) ? $clog2(count) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state_q, state_d;
   logic [rw-1:0]          remain_q, remain_d;
   logic [count*width-1:0] storage_q, storage_d;
   logic                   in_ready;
   logic                   out_valid;
   logic                   out_last;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         remain_q  <= '0;
         storage_q <= '0;
      end else begin
         state_q   <= state_d;
         remain_q  <= remain_d;
         storage_q <= storage_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      remain_d  = remain_q;
      storage_d = storage_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               storage_d = bus.in_data;
               remain_d  = rw'(count - 1);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            out_valid = 1'b1;
            out_last  = (remain_q == '0);
            if (bus.out_ready) begin
               if (!out_last) begin
                  storage_d = storage_q >> width;
                  remain_d  = remain_q - rw'(1);
               end else begin
                  // Last word leaving: reload in the same cycle to keep the stream gapless.
                  in_ready = 1'b1;
                  if (bus.in_valid) begin
                     storage_d = bus.in_data;
                     remain_d  = rw'(count - 1);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_last  = out_last;
   assign bus.out_data  = storage_q[width-1:0];
   assign bus.busy      = out_valid;
endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: cycle vector table, reset/count=1 sequences, random scoreboard run.
module tb_frame_serializer;
   logic clock;
   logic reset;
   int   total;
   int   bad;

   frame_serializer_if #(.count(4), .width(8))  bus4 ();
   frame_serializer_if #(.count(1), .width(16)) bus1 ();

   frame_serializer #(.count(4), .width(8)) u4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   frame_serializer #(.count(1), .width(16)) u1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        iv;
      logic [31:0] idat;
      logic        ordy;
      logic        ov;
      logic [7:0]  od;
      logic        ol;
      logic        ir;
      logic        cd;
   } vec_t;

   vec_t       tv[$];
   logic [8:0] sb4[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic [31:0] idat, input logic ordy,
                               input logic ov, input logic [7:0] od, input logic ol,
                               input logic ir, input logic cd);
      vec_t v;
      v.iv = iv; v.idat = idat; v.ordy = ordy;
      v.ov = ov; v.od = od; v.ol = ol; v.ir = ir; v.cd = cd;
      return v;
   endfunction

   // Scoreboard for the count=4 instance: push on frame accept, pop on word transfer.
   always @(negedge clock) begin
      if (!reset) begin
         if (bus4.out_valid && bus4.out_ready) begin
            if (sb4.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_underflow: got word %0h expected none", bus4.out_data);
            end else begin
               logic [8:0] e;
               e = sb4.pop_front();
               check("sb_data", bus4.out_data, e[7:0]);
               check("sb_last", bus4.out_last, e[8]);
            end
         end
         if (bus4.in_valid && bus4.in_ready) begin
            for (int k = 0; k < 4; k++)
               sb4.push_back({(k == 3), bus4.in_data[k*8 +: 8]});
         end
      end
   end

   initial begin
      int frames_sent;
      int cyc;
      logic have;

      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;

      // Word streams: test 2 single frame, test 3 backpressure, test 4 back-to-back.
      tv.push_back(mk(1, 32'h44332211, 1, 0, 8'h00, 0, 1, 0));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'h11, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'h22, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'h33, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'h44, 1, 1, 1));
      tv.push_back(mk(0, 32'h0,        1, 0, 8'h00, 0, 1, 0));
      tv.push_back(mk(1, 32'h44332211, 0, 0, 8'h00, 0, 1, 0));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'h11, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        0, 1, 8'h22, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        0, 1, 8'h22, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'h22, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        0, 1, 8'h33, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'h33, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'h44, 1, 1, 1));
      tv.push_back(mk(0, 32'h0,        1, 0, 8'h00, 0, 1, 0));
      tv.push_back(mk(1, 32'hA3A2A1A0, 1, 0, 8'h00, 0, 1, 0));
      tv.push_back(mk(1, 32'hB3B2B1B0, 1, 1, 8'hA0, 0, 0, 1));
      tv.push_back(mk(1, 32'hB3B2B1B0, 1, 1, 8'hA1, 0, 0, 1));
      tv.push_back(mk(1, 32'hB3B2B1B0, 1, 1, 8'hA2, 0, 0, 1));
      tv.push_back(mk(1, 32'hB3B2B1B0, 1, 1, 8'hA3, 1, 1, 1));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'hB0, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'hB1, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'hB2, 0, 0, 1));
      tv.push_back(mk(0, 32'h0,        1, 1, 8'hB3, 1, 1, 1));
      tv.push_back(mk(0, 32'h0,        1, 0, 8'h00, 0, 1, 0));

      #1;
      check("rst_out_valid", bus4.out_valid, 0);
      check("rst_out_last",  bus4.out_last,  0);
      check("rst_busy",      bus4.busy,      0);
      check("rst_out_data",  bus4.out_data,  0);
      check("rst_in_ready",  bus4.in_ready,  1);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      foreach (tv[i]) begin
         bus4.in_valid  = tv[i].iv;
         bus4.in_data   = tv[i].idat;
         bus4.out_ready = tv[i].ordy;
         @(negedge clock);
         check($sformatf("vec%0d_out_valid", i), bus4.out_valid, tv[i].ov);
         check($sformatf("vec%0d_busy", i),      bus4.busy,      tv[i].ov);
         check($sformatf("vec%0d_out_last", i),  bus4.out_last,  tv[i].ol);
         check($sformatf("vec%0d_in_ready", i),  bus4.in_ready,  tv[i].ir);
         if (tv[i].cd)
            check($sformatf("vec%0d_out_data", i), bus4.out_data, tv[i].od);
         @(posedge clock);
         #1;
      end

      // Reset mid-frame after two of four words have left.
      bus4.in_valid = 1'b1; bus4.in_data = 32'hDDCCBBAA; bus4.out_ready = 1'b1;
      @(posedge clock); #1;
      bus4.in_valid = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("pre_rst_word", bus4.out_data, 8'hCC);
      reset = 1'b1;
      #1;
      check("midrst_out_valid", bus4.out_valid, 0);
      check("midrst_out_last",  bus4.out_last,  0);
      check("midrst_busy",      bus4.busy,      0);
      check("midrst_out_data",  bus4.out_data,  0);
      check("midrst_in_ready",  bus4.in_ready,  1);
      sb4.delete();
      #1 reset = 1'b0;
      @(posedge clock); #1;
      bus4.in_valid = 1'b1; bus4.in_data = 32'h0D0C0B0A;
      @(posedge clock); #1;
      bus4.in_valid = 1'b0;
      @(negedge clock);
      check("postrst_valid", bus4.out_valid, 1);
      check("postrst_word0", bus4.out_data, 8'h0A);
      repeat (5) @(posedge clock);
      #1;

      // count=1: one word per cycle, every word last, in_ready held high.
      bus1.in_valid = 1'b1; bus1.in_data = 16'h1234; bus1.out_ready = 1'b1;
      @(negedge clock);
      check("c1_idle_in_ready", bus1.in_ready, 1);
      check("c1_idle_valid",    bus1.out_valid, 0);
      @(posedge clock); #1;
      bus1.in_data = 16'h5678;
      @(negedge clock);
      check("c1_w0_valid",    bus1.out_valid, 1);
      check("c1_w0_data",     bus1.out_data,  16'h1234);
      check("c1_w0_last",     bus1.out_last,  1);
      check("c1_w0_in_ready", bus1.in_ready,  1);
      @(posedge clock); #1;
      bus1.in_valid = 1'b0;
      @(negedge clock);
      check("c1_w1_valid",    bus1.out_valid, 1);
      check("c1_w1_data",     bus1.out_data,  16'h5678);
      check("c1_w1_last",     bus1.out_last,  1);
      check("c1_w1_in_ready", bus1.in_ready,  1);
      @(posedge clock); #1;
      @(negedge clock);
      check("c1_end_valid", bus1.out_valid, 0);
      @(posedge clock); #1;

      // Random traffic on both sides, scoreboarded.
      frames_sent = 0;
      cyc = 0;
      have = 1'b0;
      while (frames_sent < 1000 && cyc < 40000) begin
         if (!have && $urandom_range(0, 2) != 0) begin
            have = 1'b1;
            bus4.in_data = $urandom;
         end
         bus4.in_valid  = have;
         bus4.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock);
         if (have && bus4.in_ready) begin
            have = 1'b0;
            frames_sent++;
         end
         @(posedge clock); #1;
         cyc++;
      end
      check("rand_frames_sent", frames_sent, 1000);
      bus4.in_valid  = 1'b0;
      bus4.out_ready = 1'b1;
      for (int i = 0; i < 100 && (sb4.size() != 0 || bus4.out_valid); i++) begin
         @(posedge clock); #1;
      end
      check("rand_drain_left", sb4.size(), 0);
      check("rand_drain_valid", bus4.out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
